// File: rtl/bcd_entry_buffer_if.sv
// Keypad/ALU/result bus for bcd_entry_buffer.
// The slave side is the buffer. The master side is the keypad, the ALU and the result source.
interface bcd_entry_buffer_if #(
   parameter int NUM_DIGITS = 4
) ();
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic                         key_valid;
   logic [4:0]                   key_code;
   logic                         key_ready;

   logic [NUM_DIGITS-1:0][3:0]   digits;
   logic                         negative;
   logic [CW-1:0]                digit_count;
   logic                         full;

   logic                         op_valid;
   logic                         op_ready;
   logic [3:0]                   op_code;
   logic [NUM_DIGITS-1:0][3:0]   op_digits;
   logic                         op_negative;

   logic                         res_load;
   logic [NUM_DIGITS-1:0][3:0]   res_digits;
   logic                         res_negative;

   modport slave (
      input  key_valid, key_code, op_ready, res_load, res_digits, res_negative,
      output key_ready, digits, negative, digit_count, full,
             op_valid, op_code, op_digits, op_negative
   );

   modport master (
      output key_valid, key_code, op_ready, res_load, res_digits, res_negative,
      input  key_ready, digits, negative, digit_count, full,
             op_valid, op_code, op_digits, op_negative
   );
endinterface

// File: rtl/bcd_entry_buffer.sv
// Signed BCD operand entry from keypad events. The finished operand and operator
// are handed to the ALU over a valid/ready handshake, and ALU results can be loaded back for display.
module bcd_digit_slot #(
   parameter bit IS_LSD = 1'b0
) (
   input  logic [2:0] sel,
   input  logic [3:0] cur,
   input  logic [3:0] lower,
   input  logic [3:0] upper,
   input  logic [3:0] ld,
   output logic [3:0] nxt
);
   localparam logic [2:0] SL_KEEP = 3'd0, SL_ZERO = 3'd1, SL_SET = 3'd2,
                          SL_SHL  = 3'd3, SL_SHR  = 3'd4, SL_LOAD = 3'd5;

   // The LSD slot sees the key digit on its "lower" neighbour input.
   always_comb begin
      nxt = cur;
      case (sel)
         SL_ZERO: nxt = 4'd0;
         SL_SET:  nxt = IS_LSD ? lower : 4'd0;
         SL_SHL:  nxt = lower;
         SL_SHR:  nxt = upper;
         SL_LOAD: nxt = ld;
         default: nxt = cur;
      endcase
   end
endmodule

module bcd_entry_buffer #(
   parameter int NUM_DIGITS  = 4,
   parameter bit SUPPRESS_LZ = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_entry_buffer_if.slave bus
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_ENTRY   = 2'd1;
   localparam logic [1:0] S_PENDING = 2'd2;

   localparam logic [2:0] SL_KEEP = 3'd0, SL_ZERO = 3'd1, SL_SET = 3'd2,
                          SL_SHL  = 3'd3, SL_SHR  = 3'd4, SL_LOAD = 3'd5;

   logic [1:0]                 state, state_d;
   logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
   logic [NUM_DIGITS-1:0][3:0] lower_nb, upper_nb;
   logic                       neg_q, neg_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       hold_q, hold_d;
   logic                       opv_q, opv_d;
   logic [3:0]                 opc_q, opc_d;
   logic [NUM_DIGITS-1:0][3:0] opd_q, opd_d;
   logic                       opn_q, opn_d;
   logic [2:0]                 dsel;
   logic [3:0]                 key_d;
   logic                       full_w;
   logic                       is_digit, is_op;

   assign key_d    = bus.key_code[3:0];
   assign full_w   = (cnt_q == CW'(NUM_DIGITS));
   assign is_digit = (bus.key_code <= 5'd9);
   assign is_op    = (bus.key_code >= 5'd10) && (bus.key_code <= 5'd14);

   genvar i;
   generate
      for (i = 0; i < NUM_DIGITS; i++) begin : g_slot
         if (i == 0) begin : g_lsd
            assign lower_nb[i] = key_d;
         end else begin : g_mid
            assign lower_nb[i] = dig_q[i-1];
         end
         if (i == NUM_DIGITS - 1) begin : g_msd
            assign upper_nb[i] = 4'd0;
         end else begin : g_low
            assign upper_nb[i] = dig_q[i+1];
         end
         bcd_digit_slot #(.IS_LSD(i == 0)) u_slot (
            .sel   (dsel),
            .cur   (dig_q[i]),
            .lower (lower_nb[i]),
            .upper (upper_nb[i]),
            .ld    (bus.res_digits[i]),
            .nxt   (dig_d[i])
         );
      end
   endgenerate

   // Result load outranks any key in the same cycle, so the key is refused outright.
   assign bus.key_ready = (state != S_PENDING) && !bus.res_load;

   always_comb begin
      dsel    = SL_KEEP;
      state_d = state;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      opv_d   = opv_q;
      opc_d   = opc_q;
      opd_d   = opd_q;
      opn_d   = opn_q;
      if (state == S_PENDING) begin
         if (bus.op_ready) begin
            opv_d   = 1'b0;
            state_d = S_EMPTY;
         end
      end else if (bus.res_load) begin
         dsel    = SL_LOAD;
         neg_d   = bus.res_negative;
         cnt_d   = '0;
         hold_d  = 1'b1;
         state_d = S_EMPTY;
      end else if (bus.key_valid) begin
         if (is_digit) begin
            if (state == S_EMPTY) begin
               // A shown result or operand is cleared only when the first digit really lands.
               if (!(SUPPRESS_LZ && key_d == 4'd0)) begin
                  dsel    = SL_SET;
                  neg_d   = hold_q ? 1'b0 : neg_q;
                  cnt_d   = CW'(1);
                  hold_d  = 1'b0;
                  state_d = S_ENTRY;
               end
            end else if (!full_w) begin
               dsel  = SL_SHL;
               cnt_d = cnt_q + CW'(1);
            end
         end else if (is_op) begin
            opd_d   = dig_q;
            opn_d   = neg_q;
            opc_d   = 4'(bus.key_code - 5'd10);
            opv_d   = 1'b1;
            hold_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_PENDING;
         end else if (bus.key_code == 5'd15) begin
            dsel    = SL_ZERO;
            neg_d   = 1'b0;
            cnt_d   = '0;
            hold_d  = 1'b0;
            opc_d   = 4'd0;
            state_d = S_EMPTY;
         end else if (bus.key_code == 5'd16) begin
            if (state == S_ENTRY) begin
               dsel  = SL_SHR;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  neg_d   = 1'b0;
                  state_d = S_EMPTY;
               end
            end
         end else if (bus.key_code == 5'd17) begin
            neg_d = !neg_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_EMPTY;
         dig_q  <= '0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         hold_q <= 1'b0;
         opv_q  <= 1'b0;
         opc_q  <= 4'd0;
         opd_q  <= '0;
         opn_q  <= 1'b0;
      end else begin
         state  <= state_d;
         dig_q  <= dig_d;
         neg_q  <= neg_d;
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
         opv_q  <= opv_d;
         opc_q  <= opc_d;
         opd_q  <= opd_d;
         opn_q  <= opn_d;
      end
   end

   assign bus.digits      = dig_q;
   assign bus.negative    = neg_q;
   assign bus.digit_count = cnt_q;
   assign bus.full        = full_w;
   assign bus.op_valid    = opv_q;
   assign bus.op_code     = opc_q;
   assign bus.op_digits   = opd_q;
   assign bus.op_negative = opn_q;
endmodule

// File: tb/tb_bcd_entry_buffer.sv
// Scoreboarded bench for bcd_entry_buffer. A second instance with leading zeros counted
// shadows the same stimulus.
module tb_bcd_entry_buffer;
   localparam int ND = 4;
   localparam logic [4:0] K_ADD = 5'd10, K_SUB = 5'd11, K_EQ = 5'd14,
                          K_CLR = 5'd15, K_BKSP = 5'd16, K_NEG = 5'd17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bcd_entry_buffer_if #(.NUM_DIGITS(ND)) bus ();
   bcd_entry_buffer_if #(.NUM_DIGITS(ND)) bus0 ();

   bcd_entry_buffer #(.NUM_DIGITS(ND), .SUPPRESS_LZ(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   bcd_entry_buffer #(.NUM_DIGITS(ND), .SUPPRESS_LZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   assign bus0.key_valid    = bus.key_valid;
   assign bus0.key_code     = bus.key_code;
   assign bus0.op_ready     = bus.op_ready;
   assign bus0.res_load     = bus.res_load;
   assign bus0.res_digits   = bus.res_digits;
   assign bus0.res_negative = bus.res_negative;

   typedef struct {
      logic [15:0] dig;
      logic        neg;
      int          cnt;
      logic        chk0;
      logic [15:0] dig0;
      int          cnt0;
   } disp_t;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] dig;
      logic        neg;
   } op_t;

   disp_t disp_q[$];
   op_t   op_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic disp_t mk(input logic [15:0] d, input logic n, input int c);
      disp_t e;
      e.dig = d; e.neg = n; e.cnt = c; e.chk0 = 1'b0; e.dig0 = '0; e.cnt0 = 0;
      return e;
   endfunction

   function automatic disp_t mk0(input logic [15:0] d, input logic n, input int c,
                                 input logic [15:0] d0, input int c0);
      disp_t e;
      e = mk(d, n, c);
      e.chk0 = 1'b1; e.dig0 = d0; e.cnt0 = c0;
      return e;
   endfunction

   function automatic op_t mkop(input logic [3:0] c, input logic [15:0] d, input logic n);
      op_t o;
      o.code = c; o.dig = d; o.neg = n;
      return o;
   endfunction

   // Monitor: an accepted key or result load is followed by a display check; an op handshake is checked as it happens.
   always @(posedge clk) begin
      disp_t e;
      op_t   o;
      logic  ev_disp;
      if (rst_n) begin
         ev_disp = (bus.key_valid && bus.key_ready) || bus.res_load;
         if (bus.op_valid && bus.op_ready) begin
            if (op_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL op_unexpected: handshake with code %0h, no entry expected", bus.op_code);
            end else begin
               o = op_q.pop_front();
               check("op_code", 32'(bus.op_code), 32'(o.code));
               check("op_digits", 32'(bus.op_digits), 32'(o.dig));
               check("op_negative", 32'(bus.op_negative), 32'(o.neg));
            end
         end
         if (ev_disp) begin
            @(negedge clk);
            if (disp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL disp_unexpected: display %0h, no entry expected", bus.digits);
            end else begin
               e = disp_q.pop_front();
               check("digits", 32'(bus.digits), 32'(e.dig));
               check("negative", 32'(bus.negative), 32'(e.neg));
               check("digit_count", 32'(bus.digit_count), 32'(e.cnt));
               check("full", 32'(bus.full), 32'(e.cnt == ND));
               if (e.chk0) begin
                  check("lz0_digits", 32'(bus0.digits), 32'(e.dig0));
                  check("lz0_count", 32'(bus0.digit_count), 32'(e.cnt0));
               end
            end
         end
      end
   end

   task automatic press(input logic [4:0] code, input disp_t e);
      int t;
      t = 0;
      while (!bus.key_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.key_ready) begin
         n_tests++; n_fail++;
         $display("FAIL key_ready_timeout: key %0d, key_ready got 0 expected 1", code);
      end else begin
         bus.key_valid = 1'b1;
         bus.key_code  = code;
         disp_q.push_back(e);
         @(negedge clk);
         bus.key_valid = 1'b0;
      end
   endtask

   initial begin
      bus.key_valid = 1'b0; bus.key_code = '0; bus.op_ready = 1'b0;
      bus.res_load = 1'b0; bus.res_digits = '0; bus.res_negative = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_digits", 32'(bus.digits), 32'h0);
      check("rst_negative", 32'(bus.negative), 32'h0);
      check("rst_count", 32'(bus.digit_count), 32'h0);
      check("rst_op_valid", 32'(bus.op_valid), 32'h0);
      check("rst_op_code", 32'(bus.op_code), 32'h0);
      check("rst_op_digits", 32'(bus.op_digits), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("key_ready_after_rst", 32'(bus.key_ready), 32'h1);

      press(5'd1, mk(16'h0001, 1'b0, 1));
      press(5'd2, mk(16'h0012, 1'b0, 2));
      press(5'd3, mk(16'h0123, 1'b0, 3));
      press(5'd4, mk(16'h1234, 1'b0, 4));
      press(5'd5, mk(16'h1234, 1'b0, 4));
      press(K_CLR, mk(16'h0000, 1'b0, 0));

      press(5'd0, mk0(16'h0000, 1'b0, 0, 16'h0000, 1));
      press(5'd0, mk0(16'h0000, 1'b0, 0, 16'h0000, 2));
      press(5'd7, mk0(16'h0007, 1'b0, 1, 16'h0007, 3));
      press(K_CLR, mk(16'h0000, 1'b0, 0));

      press(5'd4, mk(16'h0004, 1'b0, 1));
      press(5'd2, mk(16'h0042, 1'b0, 2));
      press(K_BKSP, mk(16'h0004, 1'b0, 1));
      press(K_NEG, mk(16'h0004, 1'b1, 1));
      press(K_BKSP, mk(16'h0000, 1'b0, 0));
      press(K_BKSP, mk(16'h0000, 1'b0, 0));

      press(5'd9, mk(16'h0009, 1'b0, 1));
      op_q.push_back(mkop(4'd0, 16'h0009, 1'b0));
      press(K_ADD, mk(16'h0009, 1'b0, 0));
      for (int k = 0; k < 5; k++) begin
         check("stall_op_valid", 32'(bus.op_valid), 32'h1);
         check("stall_key_ready", 32'(bus.key_ready), 32'h0);
         check("stall_op_digits", 32'(bus.op_digits), 32'h0009);
         check("stall_op_code", 32'(bus.op_code), 32'h0);
         bus.key_valid = 1'b1;
         bus.key_code  = 5'd7;
         @(negedge clk);
      end
      bus.key_valid = 1'b0;
      check("stall_digits", 32'(bus.digits), 32'h0009);
      bus.op_ready = 1'b1;
      @(negedge clk);
      bus.op_ready = 1'b0;
      check("op_valid_dropped", 32'(bus.op_valid), 32'h0);
      check("key_ready_back", 32'(bus.key_ready), 32'h1);

      press(5'd3, mk(16'h0003, 1'b0, 1));
      bus.res_digits = 16'h0120; bus.res_negative = 1'b0;
      bus.res_load = 1'b1; bus.key_valid = 1'b1; bus.key_code = 5'd5;
      disp_q.push_back(mk(16'h0120, 1'b0, 0));
      @(negedge clk);
      bus.res_load = 1'b0; bus.key_valid = 1'b0;
      press(5'd6, mk(16'h0006, 1'b0, 1));

      press(K_NEG, mk(16'h0006, 1'b1, 1));
      bus.op_ready = 1'b1;
      op_q.push_back(mkop(4'd1, 16'h0006, 1'b1));
      press(K_SUB, mk(16'h0006, 1'b1, 0));
      press(5'd2, mk(16'h0002, 1'b0, 1));
      op_q.push_back(mkop(4'd4, 16'h0002, 1'b0));
      press(K_EQ, mk(16'h0002, 1'b0, 0));
      @(negedge clk);
      bus.op_ready = 1'b0;
      check("op_valid_after_eq", 32'(bus.op_valid), 32'h0);

      press(5'd8, mk(16'h0008, 1'b0, 1));
      press(K_ADD, mk(16'h0008, 1'b0, 0));
      check("pre_reset_op_valid", 32'(bus.op_valid), 32'h1);
      #3 rst_n = 1'b0;
      #1;
      check("async_op_valid", 32'(bus.op_valid), 32'h0);
      check("async_digits", 32'(bus.digits), 32'h0);
      check("async_count", 32'(bus.digit_count), 32'h0);
      check("async_op_digits", 32'(bus.op_digits), 32'h0);
      check("disp_q_drained", 32'(disp_q.size()), 32'h0);
      check("op_q_drained", 32'(op_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_tests++; n_fail++;
      $display("FAIL watchdog: simulation still running at time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
